// File: rtl/move_dispatcher.sv
// Requests batches of packed 4-bit move codes, scans each batch from its top nibble
// and hands every legal move to the motor driver over a valid/ready handshake.
// Optional build macro MOVE_CHECK_EN: illegal codes 1/14/15 raise a sticky error and abort to IDLE.
module move_dispatcher #(
    parameter int NUM_BATCHES = 52,
    parameter int SLOTS       = 50
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [SLOTS*4-1:0]   moves,
    input  logic                 new_moves,
    output logic                 send_setup_moves,
    output logic [5:0]           counter,
    output logic [3:0]           move,
    output logic                 move_valid,
    input  logic                 move_ready,
    output logic                 busy,
    output logic                 done_all,
    output logic                 error,
    output logic [2:0]           state_dbg
);

    localparam int         W    = SLOTS * 4;
    localparam logic [5:0] LAST = 6'(NUM_BATCHES - 1);

    // Handshake: a move transfers on the rising edge where move_valid && move_ready;
    // move holds steady while move_valid waits for move_ready, and ready is ignored otherwise.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQUEST = 3'd1,
        WAIT    = 3'd2,
        SCAN    = 3'd3,
        ISSUE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   shreg;
    logic [3:0]     top;
    logic           empty;
    logic           top_valid;
    logic           top_illegal;

    assign top       = shreg[W-1 -: 4];
    assign empty     = (shreg == '0);
    assign top_valid = (top >= 4'd2) && (top <= 4'd13);
    assign state_dbg = state;

`ifdef MOVE_CHECK_EN
    assign top_illegal = (top == 4'd1) || (top >= 4'd14);
`else
    assign top_illegal = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQUEST;
            REQUEST: state_next = WAIT;
            WAIT:    if (new_moves) state_next = SCAN;
            SCAN: begin
                if (empty) begin
                    state_next = (counter == LAST) ? DONE : REQUEST;
                end else if (top_valid) begin
                    state_next = ISSUE;
                end else if (top_illegal) begin
                    state_next = IDLE;
                end else begin
                    state_next = SCAN;
                end
            end
            ISSUE:   if (move_ready) state_next = SCAN;
            DONE:    if (start) state_next = REQUEST;
            default: state_next = IDLE;
        endcase
    end

    // Skipped and issued slots both leave the register with a zero-filled shift,
    // so an exhausted batch is simply an all-zero register.
    always_ff @(posedge clock) begin
        if (reset) begin
            counter <= '0;
            shreg   <= '0;
            move    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) counter <= '0;
                end
                WAIT: begin
                    if (new_moves) shreg <= moves;
                end
                SCAN: begin
                    if (empty) begin
                        if (counter != LAST) counter <= counter + 6'd1;
                    end else if (top_illegal) begin
                        counter <= '0;
                        shreg   <= '0;
                    end else begin
                        shreg <= shreg << 4;
                        if (top_valid) move <= top;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MOVE_CHECK_EN
    logic error_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (state == SCAN && !empty && top_illegal) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        send_setup_moves = 1'b0;
        move_valid       = 1'b0;
        busy             = 1'b0;
        done_all         = 1'b0;
        case (state)
            IDLE:    ;
            REQUEST: begin
                send_setup_moves = 1'b1;
                busy             = 1'b1;
            end
            WAIT, SCAN: busy = 1'b1;
            ISSUE: begin
                move_valid = 1'b1;
                busy       = 1'b1;
            end
            DONE:    done_all = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_move_dispatcher.sv
// Directed bench for move_dispatcher built with NUM_BATCHES=3: table of batches with
// expected move orders, plus hand sequences for zero batches, reset in ISSUE and illegal codes.
module tb_move_dispatcher;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SCAN  = 3'd3;

    logic         clock;
    logic         reset;
    logic         start;
    logic [199:0] moves;
    logic         new_moves;
    logic         send_setup_moves;
    logic [5:0]   counter;
    logic [3:0]   move;
    logic         move_valid;
    logic         move_ready;
    logic         busy;
    logic         done_all;
    logic         error;
    logic [2:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [199:0] mv;
        int           stall;
        bit           noise;
        int           n;
        logic [23:0]  e;
    } vec_t;

    vec_t vecs[6];

    move_dispatcher #(.NUM_BATCHES(3), .SLOTS(50)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .moves            (moves),
        .new_moves        (new_moves),
        .send_setup_moves (send_setup_moves),
        .counter          (counter),
        .move             (move),
        .move_valid       (move_valid),
        .move_ready       (move_ready),
        .busy             (busy),
        .done_all         (done_all),
        .error            (error),
        .state_dbg        (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, got no event, expected one", name);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_request(input int exp_cnt);
        int i;
        for (i = 0; i < 400; i++) begin
            if (send_setup_moves) break;
            @(negedge clock);
        end
        if (i == 400) timeout("request_wait");
        else chk("request_counter", 64'(counter), 64'(exp_cnt));
    endtask

    // Drives move_ready per cycle and scores every transfer against exp_q until the
    // next batch request or done_all shows up.
    task automatic collect(input int stall, input bit noise);
        int  left;
        int  g;
        bit  xfer_prev;
        left      = stall;
        xfer_prev = 1'b0;
        for (g = 0; g < 600; g++) begin
            if (send_setup_moves || done_all) break;
            if (xfer_prev) chk("valid_one_cycle", 64'(move_valid), 64'd0);
            xfer_prev = 1'b0;
            if (noise && state_dbg == S_SCAN) begin
                start     = 1'b1;
                new_moves = 1'b1;
                moves     = {50{4'h6}};
            end else begin
                start     = 1'b0;
                new_moves = 1'b0;
            end
            if (move_valid) begin
                if (left > 0) begin
                    move_ready = 1'b0;
                    if (exp_q.size() > 0) chk("stall_hold_move", 64'(move), 64'(exp_q[0]));
                    left--;
                end else begin
                    move_ready = 1'b1;
                    if (exp_q.size() == 0) chk("extra_move", 64'(move), 64'hFF);
                    else chk("move_order", 64'(move), 64'(exp_q.pop_front()));
                    xfer_prev = 1'b1;
                end
            end else begin
                move_ready = 1'b1;
            end
            @(negedge clock);
        end
        start     = 1'b0;
        new_moves = 1'b0;
        if (g == 600) timeout("batch_drain");
        chk("missing_moves", 64'(exp_q.size()), 64'd0);
        chk("stall_cycles_used", 64'(left), 64'd0);
    endtask

    task automatic serve_batch(input vec_t v, input int exp_cnt);
        for (int k = 0; k < v.n; k++) exp_q.push_back(v.e[23-4*k -: 4]);
        wait_request(exp_cnt);
        @(negedge clock);
        moves     = v.mv;
        new_moves = 1'b1;
        @(negedge clock);
        new_moves = 1'b0;
        collect(v.stall, v.noise);
    endtask

    initial begin
        int         i;
        int         n_seen;
        logic [3:0] last_move;
        bit         quiet;

        vecs[0] = '{mv: 200'h29,    stall: 0,  noise: 1'b0, n: 2, e: 24'h290000};
        vecs[1] = '{mv: 200'h745,   stall: 10, noise: 1'b0, n: 3, e: 24'h745000};
        vecs[2] = '{mv: 200'hD0A03, stall: 0,  noise: 1'b0, n: 3, e: 24'hDA3000};
        vecs[3] = '{mv: {4'h2, 192'd0, 4'hD}, stall: 0, noise: 1'b0, n: 2, e: 24'h2D0000};
        vecs[4] = '{mv: 200'h0,     stall: 0,  noise: 1'b0, n: 0, e: 24'h000000};
        vecs[5] = '{mv: 200'hCBA98, stall: 0,  noise: 1'b1, n: 5, e: 24'hCBA980};

        reset      = 1'b1;
        start      = 1'b0;
        moves      = '0;
        new_moves  = 1'b0;
        move_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_send",    64'(send_setup_moves), 64'd0);
        chk("rst_counter", 64'(counter),          64'd0);
        chk("rst_move",    64'(move),             64'd0);
        chk("rst_valid",   64'(move_valid),       64'd0);
        chk("rst_busy",    64'(busy),             64'd0);
        chk("rst_done",    64'(done_all),         64'd0);
        chk("rst_error",   64'(error),            64'd0);
        chk("rst_state",   64'(state_dbg),        64'(S_IDLE));

        // Two full three-batch sequences from the table, second one restarted from DONE.
        for (int s = 0; s < 2; s++) begin
            pulse_start();
            for (int b = 0; b < 3; b++) serve_batch(vecs[s*3 + b], b);
            chk("seq_done_all", 64'(done_all), 64'd1);
            chk("seq_busy",     64'(busy),     64'd0);
            chk("seq_counter",  64'(counter),  64'd2);
            chk("seq_error",    64'(error),    64'd0);
        end

        // All-zero batches: one SCAN cycle each, then the next request or DONE.
        pulse_start();
        for (int b = 0; b < 3; b++) begin
            wait_request(b);
            @(negedge clock);
            moves     = '0;
            new_moves = 1'b1;
            @(negedge clock);
            new_moves = 1'b0;
            chk("zero_scan_state", 64'(state_dbg), 64'(S_SCAN));
            @(negedge clock);
            if (b < 2) chk("zero_next_request", 64'(send_setup_moves), 64'd1);
            else chk("zero_done", 64'(done_all), 64'd1);
        end
        quiet = 1'b1;
        repeat (20) begin
            if (send_setup_moves || !done_all || busy) quiet = 1'b0;
            @(negedge clock);
        end
        chk("done_holds_quiet", 64'(quiet), 64'd1);

        // Reset while a move is being offered.
        pulse_start();
        wait_request(0);
        @(negedge clock);
        moves      = 200'h3;
        new_moves  = 1'b1;
        move_ready = 1'b0;
        @(negedge clock);
        new_moves = 1'b0;
        for (i = 0; i < 100; i++) begin
            if (move_valid) break;
            @(negedge clock);
        end
        if (i == 100) timeout("issue_wait");
        chk("pre_reset_move", 64'(move), 64'h3);
        reset      = 1'b1;
        move_ready = 1'b1;
        @(negedge clock);
        chk("rr_outputs", 64'({send_setup_moves, counter, move, move_valid, busy, done_all, error}), 64'd0);
        chk("rr_state",   64'(state_dbg), 64'(S_IDLE));
        reset = 1'b0;
        quiet = 1'b1;
        repeat (60) begin
            if (send_setup_moves || move_valid || busy || state_dbg != S_IDLE) quiet = 1'b0;
            @(negedge clock);
        end
        chk("rr_stays_idle", 64'(quiet), 64'd1);

        // Illegal nibble above a legal move.
        pulse_start();
        wait_request(0);
        @(negedge clock);
        moves     = 200'hF3;
        new_moves = 1'b1;
        @(negedge clock);
        new_moves = 1'b0;
        n_seen    = 0;
        last_move = '0;
        for (i = 0; i < 200; i++) begin
            if (move_valid) begin
                n_seen++;
                last_move = move;
            end
`ifdef MOVE_CHECK_EN
            if (state_dbg == S_IDLE) break;
`endif
            @(negedge clock);
        end
`ifdef MOVE_CHECK_EN
        chk("chk_error",   64'(error),     64'd1);
        chk("chk_state",   64'(state_dbg), 64'(S_IDLE));
        chk("chk_counter", 64'(counter),   64'd0);
        chk("chk_no_move", 64'(n_seen),    64'd0);
        repeat (5) @(negedge clock);
        chk("chk_sticky",  64'(error),     64'd1);
`else
        chk("skip_move_count", 64'(n_seen),    64'd1);
        chk("skip_move_code",  64'(last_move), 64'h3);
        chk("skip_error",      64'(error),     64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_dispatcher.md
MOVE_DISPATCHER -- requirements
Module: move_dispatcher

Interface
REQ-001 SHALL have parameter NUM_BATCHES, default 52, giving the number of move batches per full sequence.
REQ-002 SHALL have parameter SLOTS, default 50, giving the number of 4-bit move slots in one batch word.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: begins a full sequence when the block is idle.
REQ-006 SHALL have port moves, input, 200 bits: packed batch word; the first move is in the highest non-zero nibble and the last move is in nibble [3:0].
REQ-007 SHALL have port new_moves, input, 1 bit: one-cycle strobe marking moves as valid.
REQ-008 SHALL have port send_setup_moves, output, 1 bit: one-cycle request for the next batch.
REQ-009 SHALL have port counter, output, 6 bits: index of the batch being requested or consumed.
REQ-010 SHALL have port move, output, 4 bits: current move code (R=2 through Di=13).
REQ-011 SHALL have port move_valid, output, 1 bit: move is presented to the motor driver.
REQ-012 SHALL have port move_ready, input, 1 bit: the motor driver accepts move.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-014 SHALL have port done_all, output, 1 bit: high while in DONE.
REQ-015 SHALL have port error, output, 1 bit: sticky illegal-code flag (see Configuration).

Function
REQ-016 SHALL implement the states IDLE, REQUEST, WAIT, SCAN, ISSUE and DONE.
REQ-017 IDLE: when start=1, counter SHALL be set to 0 and the block SHALL go to REQUEST; otherwise it stays in IDLE.
REQ-018 REQUEST SHALL last exactly one cycle with send_setup_moves=1, then go to WAIT.
REQ-019 WAIT: when new_moves=1, a 200-bit shift register SHALL load moves on that edge and the block SHALL go to SCAN; new_moves in any other state is ignored.
REQ-020 SCAN, each cycle, if the whole shift register is 0: the batch is complete and SHALL go to the next-batch step (REQ-024).
REQ-021 SCAN, each cycle, if the top nibble [199:196] is 2..13: move SHALL load that nibble, the register SHALL shift left by 4 with zero fill, and the block SHALL go to ISSUE.
REQ-022 SCAN, each cycle, if the top nibble is anything else: the register SHALL shift left by 4 and the block stays in SCAN; each skipped slot costs one cycle.
REQ-023 ISSUE SHALL hold move_valid=1 and move stable until move_ready=1; the transfer occurs on the edge where valid&ready=1, after which the block SHALL return to SCAN with move_valid=0.
REQ-024 Next-batch step: if counter==NUM_BATCHES-1 the block SHALL go to DONE; otherwise counter SHALL increment by 1 and the block SHALL go to REQUEST.
REQ-025 Moves SHALL be issued in order from highest to lowest nibble; each move is issued exactly once and none is dropped or duplicated.
REQ-026 An all-zero batch SHALL issue no moves and SHALL advance to the next batch after 1 SCAN cycle.
REQ-027 DONE SHALL hold done_all=1 until start=1, which restarts at counter=0 via REQUEST.
REQ-028 start in REQUEST, WAIT, SCAN or ISSUE SHALL be ignored.
REQ-029 move_ready outside ISSUE SHALL be ignored.
REQ-030 The earliest move_valid after loading SHALL occur one cycle after the SCAN cycle that finds the move.
REQ-031 counter SHALL never exceed NUM_BATCHES-1 and SHALL never wrap.

Reset
REQ-032 reset=1 at any edge SHALL force state=IDLE, counter=0, shift register=0, move=0, move_valid=0, send_setup_moves=0, busy=0, done_all=0, error=0, overriding all other inputs including a handshake in progress.
REQ-033 The block SHALL not issue a partially dispatched batch after reset; restarting requires start.

Configuration
REQ-034 With MOVE_CHECK_EN defined, a top nibble of 1, 14 or 15 seen in SCAN SHALL set error=1 (sticky until reset) and force IDLE with counter=0; nibble 0 remains a skip.
REQ-035 Without MOVE_CHECK_EN, codes 0, 1, 14 and 15 SHALL all be skipped silently and error SHALL be tied to 0.

Verification
REQ-036 Verification SHALL cover: start; on the first request reply with moves={R,Li} (i.e. 0x...0029) and new_moves, with move_ready=1 -> move=2 then move=9, each valid for 1 cycle, then send_setup_moves with counter=1.
REQ-037 Verification SHALL cover: batch {Fi,U,Ui} with move_ready held low 10 cycles -> move=7 held stable with valid=1 for all 10 cycles, then 4 and 5 follow in order.
REQ-038 Verification SHALL cover: NUM_BATCHES=3 with all-zero batches -> 3 request pulses with counter 0, 1, 2, then done_all=1 and busy=0.
REQ-039 Verification SHALL cover: reset asserted in ISSUE with move_valid=1 -> next cycle all outputs are 0, state is IDLE, and no further requests are issued without start.
REQ-040 Verification SHALL cover: with MOVE_CHECK_EN, batch nibble 0xF above a valid move -> error=1, no moves issued, IDLE; without MOVE_CHECK_EN the same batch issues the valid move and error=0.
REQ-041 Verification SHALL cover: start and new_moves pulsed during SCAN -> both ignored; the issued sequence is unchanged.
